// File: rtl/rv_pkg.sv
// Shared RV32 pipeline types: opcodes, control bundle, ID/EX data bundle.
// Imported by every pipeline stage.
package rv_pkg;

  localparam logic [6:0] R_TYPE       = 7'b0110011;
  localparam logic [6:0] LW           = 7'b0000011;
  localparam logic [6:0] SW           = 7'b0100011;
  localparam logic [6:0] BR           = 7'b1100011;
  localparam logic [6:0] INT_IMED_REG = 7'b0010011;
  localparam logic [6:0] JAL          = 7'b1101111;
  localparam logic [6:0] JALR         = 7'b1100111;
  localparam logic [6:0] LUI          = 7'b0110111;

  typedef struct packed {
    logic       valid;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       jalrsel;
    logic [1:0] aluop;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [6:0]  opcode;
  } id_ex_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the load in EX and the instruction in ID.
// Purely combinational; flush overrides the stall.
import rv_pkg::*;

module hazard_detect (
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [6:0] id_opcode,
  input  logic       flush,
  output logic       hazard,
  output logic       stall
);

  logic use_rs1;
  logic use_rs2;

  always_comb begin
    use_rs1 = 1'b1;
    unique case (id_opcode)
      LUI, JAL: use_rs1 = 1'b0;
      default:  use_rs1 = 1'b1;
    endcase
  end

  always_comb begin
    use_rs2 = 1'b0;
    unique case (id_opcode)
      R_TYPE, SW, BR: use_rs2 = 1'b1;
      default:        use_rs2 = 1'b0;
    endcase
  end

  // x0 is never a real destination, so it cannot create a dependency
  assign hazard = ex_valid && ex_memread && (ex_rd != 5'd0) &&
                  ((use_rs1 && (ex_rd == id_rs1)) ||
                   (use_rs2 && (ex_rd == id_rs2)));

  assign stall = hazard && !flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and a
// saturating bubble counter.
import rv_pkg::*;

module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        alusrc,
  input  logic        memtoreg,
  input  logic        regwrite,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        branch,
  input  logic        jalrsel,
  input  logic [1:0]  aluop,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rd1,
  input  logic [31:0] id_rd2,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [2:0]  id_funct3,
  input  logic [6:0]  id_funct7,
  input  logic [6:0]  id_opcode,
  input  logic        flush,
  output logic        stall,
  output logic        ex_alusrc,
  output logic        ex_memtoreg,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_branch,
  output logic        ex_jalrsel,
  output logic [1:0]  ex_aluop,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rd1,
  output logic [31:0] ex_rd2,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [2:0]  ex_funct3,
  output logic [6:0]  ex_funct7,
  output logic [6:0]  ex_opcode,
  output logic        ex_valid,
  output logic [15:0] bubble_cnt
);

  ctrl_t  c_in, ctrl_q;
  id_ex_t d_in, ex_q;
  logic   hazard;
  logic   bubble;
  logic [15:0] cnt_q;

  assign c_in = '{valid: 1'b1, alusrc: alusrc,
                  memtoreg: memtoreg, regwrite: regwrite,
                  memread: memread, memwrite: memwrite,
                  branch: branch, jalrsel: jalrsel,
                  aluop: aluop};

  assign d_in = '{pc: id_pc, rd1: id_rd1, rd2: id_rd2,
                  imm: id_imm, rs1: id_rs1, rs2: id_rs2,
                  rd: id_rd, funct3: id_funct3,
                  funct7: id_funct7, opcode: id_opcode};

  hazard_detect u_hazard (
    .ex_valid   (ctrl_q.valid),
    .ex_memread (ctrl_q.memread),
    .ex_rd      (ex_q.rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_opcode  (id_opcode),
    .flush      (flush),
    .hazard     (hazard),
    .stall      (stall)
  );

  assign bubble = hazard || flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= BUBBLE_CTRL;
      ex_q   <= '0;
      cnt_q  <= '0;
    end else if (bubble) begin
      ctrl_q <= BUBBLE_CTRL;
      ex_q   <= '0;
      if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end else begin
      ctrl_q <= c_in;
      ex_q   <= d_in;
    end
  end

  assign ex_valid    = ctrl_q.valid;
  assign ex_alusrc   = ctrl_q.alusrc;
  assign ex_memtoreg = ctrl_q.memtoreg;
  assign ex_regwrite = ctrl_q.regwrite;
  assign ex_memread  = ctrl_q.memread;
  assign ex_memwrite = ctrl_q.memwrite;
  assign ex_branch   = ctrl_q.branch;
  assign ex_jalrsel  = ctrl_q.jalrsel;
  assign ex_aluop    = ctrl_q.aluop;
  assign ex_pc       = ex_q.pc;
  assign ex_rd1      = ex_q.rd1;
  assign ex_rd2      = ex_q.rd2;
  assign ex_imm      = ex_q.imm;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_rd       = ex_q.rd;
  assign ex_funct3   = ex_q.funct3;
  assign ex_funct7   = ex_q.funct7;
  assign ex_opcode   = ex_q.opcode;
  assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: pass-through, load-use, filters,
// flush collision, reset and counter saturation.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        alusrc, memtoreg, regwrite, memread;
  logic        memwrite, branch, jalrsel;
  logic [1:0]  aluop;
  logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7, id_opcode;
  logic        flush;
  logic        stall;
  logic        ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread;
  logic        ex_memwrite, ex_branch, ex_jalrsel;
  logic [1:0]  ex_aluop;
  logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7, ex_opcode;
  logic        ex_valid;
  logic [15:0] bubble_cnt;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .alusrc(alusrc), .memtoreg(memtoreg), .regwrite(regwrite),
    .memread(memread), .memwrite(memwrite), .branch(branch),
    .jalrsel(jalrsel), .aluop(aluop),
    .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_opcode(id_opcode), .flush(flush), .stall(stall),
    .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
    .ex_jalrsel(ex_jalrsel), .ex_aluop(ex_aluop),
    .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_opcode(ex_opcode), .ex_valid(ex_valid),
    .bubble_cnt(bubble_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic mr, input logic rw,
                       input logic [1:0] aop);
    id_opcode = op;  id_rd = rd;  id_rs1 = rs1;  id_rs2 = rs2;
    id_rd1 = a;  id_rd2 = b;  memread = mr;  regwrite = rw;
    aluop = aop;  memtoreg = mr;  alusrc = mr;
    memwrite = 1'b0;  branch = 1'b0;  jalrsel = 1'b0;
    id_pc = 32'h100;  id_imm = 32'h4;
    id_funct3 = 3'd0;  id_funct7 = 7'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    drive(7'b0110011, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 1'b0, 1'b1, 2'b10);
    #3;
    total++;
    if (ex_valid !== 1'b0 || bubble_cnt !== 16'd0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_init: valid=%b cnt=%h stall=%b want 0 0 0",
               ex_valid, bubble_cnt, stall);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    total++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd3) begin
      bad++;
      $display("FAIL first_capture: valid=%b rd=%0d want 1 3",
               ex_valid, ex_rd);
    end
    // load x5 then dependent add, then reset mid-stall
    drive(7'b0000011, 5'd5, 5'd1, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 2'b00);
    step();
    drive(7'b0110011, 5'd6, 5'd5, 5'd1, 32'd1, 32'd2, 1'b0, 1'b1, 2'b10);
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_stall: stall=%b want 1", stall);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0 || ex_regwrite !== 1'b0 || ex_memread !== 1'b0 ||
        ex_rd !== 5'd0 || ex_pc !== 32'd0 || ex_valid !== 1'b0 ||
        bubble_cnt !== 16'd0) begin
      bad++;
      $display("FAIL async_reset: stall=%b rw=%b mr=%b rd=%0d pc=%h v=%b cnt=%h want all 0",
               stall, ex_regwrite, ex_memread, ex_rd, ex_pc, ex_valid,
               bubble_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 16'd0;
  endtask

  task automatic test_passthrough();
    drive(7'b0110011, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 1'b0, 1'b1, 2'b10);
    step();
    total++;
    if (ex_regwrite !== 1'b1 || ex_aluop !== 2'b10 || ex_rd1 !== 32'd5 ||
        ex_rd2 !== 32'd7 || ex_rd !== 5'd3 || ex_valid !== 1'b1 ||
        stall !== 1'b0 || ex_opcode !== 7'b0110011 || ex_pc !== 32'h100) begin
      bad++;
      $display("FAIL passthrough: rw=%b aop=%b a=%0d b=%0d rd=%0d v=%b st=%b op=%b pc=%h want 1 10 5 7 3 1 0 0110011 100",
               ex_regwrite, ex_aluop, ex_rd1, ex_rd2, ex_rd, ex_valid,
               stall, ex_opcode, ex_pc);
    end
  endtask

  task automatic test_load_use();
    drive(7'b0000011, 5'd5, 5'd1, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 2'b00);
    step();
    drive(7'b0110011, 5'd6, 5'd5, 5'd1, 32'd9, 32'd4, 1'b0, 1'b1, 2'b10);
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL load_use_stall: stall=%b want 1", stall);
    end
    step();
    exp_cnt = exp_cnt + 16'd1;
    total++;
    if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_memread !== 1'b0 ||
        ex_memtoreg !== 1'b0 || ex_alusrc !== 1'b0 || ex_aluop !== 2'b00 ||
        ex_rd !== 5'd0 || ex_rd1 !== 32'd0 || bubble_cnt !== exp_cnt ||
        stall !== 1'b0) begin
      bad++;
      $display("FAIL load_use_bubble: v=%b rw=%b mr=%b aop=%b rd=%0d cnt=%h st=%b want 0 0 0 00 0 %h 0",
               ex_valid, ex_regwrite, ex_memread, ex_aluop, ex_rd,
               bubble_cnt, stall, exp_cnt);
    end
    step();
    total++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_rd1 !== 32'd9 ||
        stall !== 1'b0 || bubble_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL load_use_resume: v=%b rd=%0d a=%0d st=%b cnt=%h want 1 6 9 0 %h",
               ex_valid, ex_rd, ex_rd1, stall, bubble_cnt, exp_cnt);
    end
  endtask

  task automatic test_filters();
    drive(7'b0000011, 5'd0, 5'd1, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 2'b00);
    step();
    drive(7'b0110011, 5'd6, 5'd0, 5'd0, 32'd1, 32'd1, 1'b0, 1'b1, 2'b10);
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL x0_filter: stall=%b want 0", stall);
    end
    drive(7'b0000011, 5'd5, 5'd1, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 2'b00);
    step();
    drive(7'b0110111, 5'd7, 5'd5, 5'd5, 32'd0, 32'd0, 1'b0, 1'b1, 2'b00);
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL lui_filter: stall=%b want 0", stall);
    end
    step();
    total++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || bubble_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL lui_capture: v=%b rd=%0d cnt=%h want 1 7 %h",
               ex_valid, ex_rd, bubble_cnt, exp_cnt);
    end
    // store in EX with rd field 5 must not hazard
    drive(7'b0100011, 5'd5, 5'd1, 5'd2, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00);
    memwrite = 1'b1;
    step();
    drive(7'b0110011, 5'd6, 5'd5, 5'd5, 32'd0, 32'd0, 1'b0, 1'b1, 2'b10);
    #1;
    total++;
    if (stall !== 1'b0 || ex_memwrite !== 1'b1) begin
      bad++;
      $display("FAIL store_filter: stall=%b mw=%b want 0 1",
               stall, ex_memwrite);
    end
    step();
  endtask

  task automatic test_flush_collision();
    drive(7'b0000011, 5'd5, 5'd1, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 2'b00);
    step();
    drive(7'b0110011, 5'd6, 5'd5, 5'd1, 32'd3, 32'd3, 1'b0, 1'b1, 2'b10);
    flush = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL flush_stall: stall=%b want 0", stall);
    end
    step();
    flush = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    total++;
    if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || bubble_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL flush_bubble: v=%b rw=%b cnt=%h want 0 0 %h",
               ex_valid, ex_regwrite, bubble_cnt, exp_cnt);
    end
    step();
    total++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || bubble_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL flush_after: v=%b rd=%0d cnt=%h want 1 6 %h",
               ex_valid, ex_rd, bubble_cnt, exp_cnt);
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    exp_cnt = 16'd0;
    flush = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    total++;
    if (bubble_cnt !== 16'hFFFE) begin
      bad++;
      $display("FAIL sat_preload: cnt=%h want FFFE", bubble_cnt);
    end
    step();
    total++;
    if (bubble_cnt !== 16'hFFFF) begin
      bad++;
      $display("FAIL sat_reach: cnt=%h want FFFF", bubble_cnt);
    end
    step();
    step();
    total++;
    if (bubble_cnt !== 16'hFFFF) begin
      bad++;
      $display("FAIL sat_hold: cnt=%h want FFFF", bubble_cnt);
    end
    flush = 1'b0;
  endtask

  initial begin
    exp_cnt = 16'd0;
    test_reset();
    test_passthrough();
    test_load_use();
    test_filters();
    test_flush_collision();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
